// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared constants, request struct and byte-lane helpers for the data-memory responder
package mem_responder_pkg;

   localparam int RAM_DEPTH = 1024;
   localparam int RAM_AW    = 10;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_RD_WAIT  = 3'd1;
   localparam logic [2:0] ST_MERGE_WR = 3'd2;
   localparam logic [2:0] ST_WR       = 3'd3;
   localparam logic [2:0] ST_RESP     = 3'd4;

   localparam logic ACC_BYTE  = 1'b0;
   localparam logic ACC_WORD  = 1'b1;
   localparam logic ACC_LOAD  = 1'b0;
   localparam logic ACC_STORE = 1'b1;

   // Only the low 12 address bits matter: the array wraps every 4 KiB.
   typedef struct packed {
      logic        we;
      logic        word;
      logic [11:0] addr;
      logic [31:0] wdata;
   } mem_req_t;

   function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [1:0] lane);
      return (w >> {lane, 3'b000}) & 32'h0000_00FF;
   endfunction

   function automatic logic [31:0] lane_merge(input logic [31:0] w, input logic [1:0] lane,
                                              input logic [7:0] b);
      logic [4:0] sh;
      sh = {lane, 3'b000};
      return (w & ~(32'h0000_00FF << sh)) | ({24'h0, b} << sh);
   endfunction

   function automatic logic misaligned(input logic word, input logic [1:0] lo);
      return (word == ACC_WORD) && (lo != 2'b00);
   endfunction

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - single-port 1024x32 data RAM, synchronous read and write
module dmem_ram
   import mem_responder_pkg::*;
(
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [RAM_AW-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] mem_q [RAM_DEPTH];
   logic [31:0] rdata_q;

   // No reset: contents survive a controller reset.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem_q[addr] <= wdata;
         end else begin
            rdata_q <= mem_q[addr];
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-outstanding load/store responder with byte read-modify-write
module mem_responder
   import mem_responder_pkg::*;
(
   input  logic        Clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic        req_word,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   logic [2:0]        state_q, state_d;
   mem_req_t          req_q, req_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              accept;
   logic              ram_en, ram_we;
   logic [RAM_AW-1:0] ram_addr;
   logic [31:0]       ram_wdata, ram_rdata;
   logic              err;
   logic              unused_addr_hi;

   assign unused_addr_hi = ^req_addr[31:12];
   assign req_ready      = (state_q == ST_IDLE);
   assign accept         = req_valid && req_ready;

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      rdata_d   = rdata_q;
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = req_q.addr[11:2];
      ram_wdata = req_q.wdata;
      case (state_q)
         ST_IDLE: begin
            // Reads are launched straight from the request inputs to save a cycle.
            ram_addr = req_addr[11:2];
            if (accept) begin
               req_d = '{we: req_we, word: req_word, addr: req_addr[11:0], wdata: req_wdata};
               if (misaligned(req_word, req_addr[1:0])) begin
                  state_d = ST_RESP;
               end else if (req_we == ACC_STORE && req_word == ACC_WORD) begin
                  state_d = ST_WR;
               end else begin
                  state_d = ST_RD_WAIT;
                  ram_en  = 1'b1;
               end
            end
         end
         ST_RD_WAIT: begin
            rdata_d = ram_rdata;
            state_d = (req_q.we == ACC_STORE) ? ST_MERGE_WR : ST_RESP;
         end
         ST_MERGE_WR: begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_wdata = lane_merge(rdata_q, req_q.addr[1:0], req_q.wdata[7:0]);
            state_d   = ST_RESP;
         end
         ST_WR: begin
            ram_en  = 1'b1;
            ram_we  = 1'b1;
            state_d = ST_RESP;
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         req_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         rdata_q <= rdata_d;
      end
   end

   dmem_ram u_ram (
      .clk   (Clk),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   assign rsp_valid = (state_q == ST_RESP);
   assign err       = rsp_valid && misaligned(req_q.word, req_q.addr[1:0]);
   assign rsp_err   = err;
   assign rsp_rdata = (rsp_valid && !err && req_q.we == ACC_LOAD)
                    ? ((req_q.word == ACC_BYTE) ? lane_extract(rdata_q, req_q.addr[1:0]) : rdata_q)
                    : 32'h0;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed and randomized checks of mem_responder against a word-array model
module tb_mem_responder;

   logic        Clk = 1'b0;
   logic        reset;
   logic        req_valid, req_we, req_word;
   logic [31:0] req_addr, req_wdata;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] mem_m [1024];

   typedef struct {
      bit          got;
      int          lat;
      logic [31:0] rdata;
      logic        err;
      logic        ready_at_rsp;
      logic        post_valid;
      logic        post_ready;
      logic [31:0] post_rdata;
      logic        post_err;
   } obs_t;

   always #5 Clk = ~Clk;

   mem_responder dut (
      .Clk       (Clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_we    (req_we),
      .req_word  (req_word),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   function automatic logic rbit();
      return ($urandom() & 32'd1) != 32'd0;
   endfunction

   // Reference: plain word array, little-endian byte lanes, 4 KiB wrap.
   function automatic void model(input logic we, input logic word, input logic [31:0] addr,
                                 input logic [31:0] wdata, output logic [31:0] er,
                                 output logic ee, output int el);
      logic [9:0] idx;
      int         sh;
      idx = addr[11:2];
      sh  = 8 * int'(addr[1:0]);
      er  = 32'h0;
      ee  = 1'b0;
      if (word && addr[1:0] != 2'b00) begin
         ee = 1'b1;
         el = 1;
      end else if (we && word) begin
         mem_m[idx] = wdata;
         el = 2;
      end else if (we) begin
         mem_m[idx][sh +: 8] = wdata[7:0];
         el = 3;
      end else begin
         el = 2;
         er = word ? mem_m[idx] : {24'h0, mem_m[idx][sh +: 8]};
      end
   endfunction

   // Called at a negedge with the DUT idle; returns at the negedge after the response.
   task automatic run_req(input logic we, input logic word, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit busy_noise, output obs_t o);
      o = '{got: 1'b0, lat: 99, rdata: 32'h0, err: 1'b0, ready_at_rsp: 1'b1,
            post_valid: 1'b1, post_ready: 1'b0, post_rdata: 32'h0, post_err: 1'b0};
      req_valid = 1'b1;
      req_we    = we;
      req_word  = word;
      req_addr  = addr;
      req_wdata = wdata;
      @(posedge Clk);
      for (int c = 1; c <= 8 && !o.got; c++) begin
         @(negedge Clk);
         if (rsp_valid) begin
            o.got          = 1'b1;
            o.lat          = c;
            o.rdata        = rsp_rdata;
            o.err          = rsp_err;
            o.ready_at_rsp = req_ready;
         end
         req_valid = busy_noise;
         req_we    = rbit();
         req_word  = rbit();
         req_addr  = $urandom();
         req_wdata = $urandom();
      end
      @(negedge Clk);
      o.post_valid = rsp_valid;
      o.post_ready = req_ready;
      o.post_rdata = rsp_rdata;
      o.post_err   = rsp_err;
      req_valid    = 1'b0;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_word  = 1'b1;
      req_addr  = 32'h0;
      req_wdata = 32'h0;
      repeat (3) @(negedge Clk);
      vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got=%b want=1", req_ready); end
      vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
      vectors++; if (rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rsp_rdata got=%h want=0", rsp_rdata); end
      vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_err got=%b want=0", rsp_err); end
      req_valid = 1'b0;
      reset     = 1'b0;
      @(negedge Clk);
   endtask

   task automatic test_word_rw();
      obs_t o; logic [31:0] er; logic ee; int el;
      model(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, er, ee, el);
      run_req(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, o);
      vectors++; if (!o.got || o.lat != 2) begin miscompares++; $display("FAIL word_store_lat got=%0d want=2", o.lat); end
      model(1'b0, 1'b1, 32'h10, 32'h0, er, ee, el);
      run_req(1'b0, 1'b1, 32'h10, 32'h0, 1'b0, o);
      vectors++; if (!o.got || o.lat != 2) begin miscompares++; $display("FAIL word_load_lat got=%0d want=2", o.lat); end
      vectors++; if (o.rdata !== 32'hDEADBEEF || o.err !== 1'b0) begin miscompares++; $display("FAIL word_load_data got=%h err=%b want=deadbeef err=0", o.rdata, o.err); end
   endtask

   task automatic test_byte_store();
      obs_t o; logic [31:0] er; logic ee; int el;
      model(1'b1, 1'b0, 32'h12, 32'h123456AA, er, ee, el);
      run_req(1'b1, 1'b0, 32'h12, 32'h123456AA, 1'b0, o);
      vectors++; if (!o.got || o.lat != 3) begin miscompares++; $display("FAIL byte_store_lat got=%0d want=3", o.lat); end
      model(1'b0, 1'b1, 32'h10, 32'h0, er, ee, el);
      run_req(1'b0, 1'b1, 32'h10, 32'h0, 1'b0, o);
      vectors++; if (o.rdata !== 32'hDEAABEEF) begin miscompares++; $display("FAIL byte_store_merge got=%h want=deaabeef", o.rdata); end
   endtask

   task automatic test_byte_load();
      obs_t o; logic [31:0] er; logic ee; int el;
      model(1'b0, 1'b0, 32'h13, 32'h0, er, ee, el);
      run_req(1'b0, 1'b0, 32'h13, 32'h0, 1'b0, o);
      vectors++; if (!o.got || o.lat != 2 || o.rdata !== 32'h000000DE) begin miscompares++; $display("FAIL byte_load got=%h lat=%0d want=000000de lat=2", o.rdata, o.lat); end
   endtask

   task automatic test_misaligned();
      obs_t o; logic [31:0] er; logic ee; int el;
      model(1'b0, 1'b1, 32'h11, 32'h0, er, ee, el);
      run_req(1'b0, 1'b1, 32'h11, 32'h0, 1'b0, o);
      vectors++; if (!o.got || o.lat != 1) begin miscompares++; $display("FAIL misaligned_lat got=%0d want=1", o.lat); end
      vectors++; if (o.err !== 1'b1 || o.rdata !== 32'h0) begin miscompares++; $display("FAIL misaligned_resp got err=%b rdata=%h want err=1 rdata=0", o.err, o.rdata); end
      run_req(1'b0, 1'b1, 32'h10, 32'h0, 1'b0, o);
      vectors++; if (o.rdata !== 32'hDEAABEEF || o.err !== 1'b0) begin miscompares++; $display("FAIL after_misaligned got=%h err=%b want=deaabeef err=0", o.rdata, o.err); end
   endtask

   task automatic test_wrap();
      obs_t o; logic [31:0] er; logic ee; int el;
      model(1'b1, 1'b1, 32'h1004, 32'h12345678, er, ee, el);
      run_req(1'b1, 1'b1, 32'h1004, 32'h12345678, 1'b0, o);
      run_req(1'b0, 1'b1, 32'h0004, 32'h0, 1'b0, o);
      vectors++; if (o.rdata !== 32'h12345678) begin miscompares++; $display("FAIL wrap_4k got=%h want=12345678", o.rdata); end
   endtask

   task automatic test_reset_abort();
      obs_t o;
      bit   seen;
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_word  = 1'b0;
      req_addr  = 32'h12;
      req_wdata = 32'h00000055;
      @(posedge Clk);
      @(negedge Clk);
      reset     = 1'b1;
      req_valid = 1'b0;
      seen      = 1'b0;
      repeat (3) begin
         @(negedge Clk);
         if (rsp_valid) seen = 1'b1;
      end
      reset = 1'b0;
      repeat (3) begin
         @(negedge Clk);
         if (rsp_valid) seen = 1'b1;
      end
      vectors++; if (seen) begin miscompares++; $display("FAIL abort_no_rsp got rsp_valid=1 want none"); end
      vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL abort_ready got=%b want=1", req_ready); end
      run_req(1'b0, 1'b1, 32'h10, 32'h0, 1'b0, o);
      vectors++; if (o.rdata !== 32'hDEAABEEF) begin miscompares++; $display("FAIL abort_no_write got=%h want=deaabeef", o.rdata); end
   endtask

   task automatic test_random();
      obs_t o; logic [31:0] er; logic ee; int el;
      logic we, word;
      logic [31:0] a, d;
      for (int i = 0; i < 32; i++) begin
         if (i == 1 || i == 4) continue;
         a = 32'(i) << 2;
         d = $urandom();
         model(1'b1, 1'b1, a, d, er, ee, el);
         run_req(1'b1, 1'b1, a, d, 1'b0, o);
         vectors++; if (!o.got || o.lat != 2) begin miscompares++; $display("FAIL init_store[%0d] got lat=%0d want=2", i, o.lat); end
      end
      for (int i = 0; i < 300; i++) begin
         we   = rbit();
         word = rbit();
         a    = ($urandom() & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2)
              | 32'($urandom_range(0, 3));
         if (word && rbit()) a[1:0] = 2'b00;
         d = $urandom();
         model(we, word, a, d, er, ee, el);
         run_req(we, word, a, d, rbit(), o);
         vectors++;
         if (!o.got || o.lat != el || o.rdata !== er || o.err !== ee || o.ready_at_rsp !== 1'b0) begin
            miscompares++;
            $display("FAIL rand[%0d] we=%b word=%b addr=%h got lat=%0d rdata=%h err=%b ready=%b want lat=%0d rdata=%h err=%b ready=0",
                     i, we, word, a, o.lat, o.rdata, o.err, o.ready_at_rsp, el, er, ee);
         end
         vectors++;
         if (o.post_valid !== 1'b0 || o.post_ready !== 1'b1 || o.post_rdata !== 32'h0 || o.post_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rand_post[%0d] got valid=%b ready=%b rdata=%h err=%b want 0/1/0/0",
                     i, o.post_valid, o.post_ready, o.post_rdata, o.post_err);
         end
      end
   endtask

   initial begin
      test_reset();
      test_word_rw();
      test_byte_store();
      test_byte_load();
      test_misaligned();
      test_wrap();
      test_reset_abort();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Clk  input  1  single system clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 req_valid  input  1  data-memory request from the control FSM is present.
REQ-004 req_we  input  1  1 = store, 0 = load.
REQ-005 req_word  input  1  1 = word access, 0 = byte access (same meaning as Mem_Out_sel / Mem_DataIn_sel).
REQ-006 req_addr  input  32  byte address computed by the ALU.
REQ-007 req_wdata  input  32  store data; byte stores use bits 7:0 only.
REQ-008 req_ready  output  1  responder can accept a request this cycle.
REQ-009 rsp_valid  output  1  one-cycle pulse marking request completion.
REQ-010 rsp_rdata  output  32  load result; valid only while rsp_valid=1.
REQ-011 rsp_err  output  1  misaligned word access; valid only while rsp_valid=1.

Function
REQ-012 Storage: 1024 x 32-bit words; word index = req_addr[11:2]; req_addr[31:12] ignored, so addresses wrap modulo 4 KiB.
REQ-013 Byte lanes are little-endian: addr[1:0]=0 selects bits 7:0, 1 selects 15:8, 2 selects 23:16, 3 selects 31:24.
REQ-014 FSM states: IDLE, RD_WAIT, MERGE_WR, WR, RESP.
REQ-015 req_ready SHALL be 1 in IDLE only; a request is accepted on a rising edge with req_valid=1 and req_ready=1; req_we, req_word, req_addr and req_wdata are captured at acceptance and later input changes are ignored.
REQ-016 Word load: IDLE->RD_WAIT->RESP->IDLE; RAM read is issued on acceptance; rsp_rdata = full word.
REQ-017 Byte load: same path and timing as a word load; rsp_rdata = selected byte zero-extended to 32 bits.
REQ-018 Word store: IDLE->WR->RESP->IDLE; the RAM write occurs in WR.
REQ-019 Byte store (read-modify-write): IDLE->RD_WAIT->MERGE_WR->RESP->IDLE; the selected lane is replaced by req_wdata[7:0]; the other three bytes are preserved.
REQ-020 Misaligned word access (req_word=1, addr[1:0]!=0): IDLE->RESP directly; no RAM access; rsp_err=1; rsp_rdata=0.
REQ-021 Byte accesses are never misaligned.
REQ-022 Latency from acceptance edge to rsp_valid: loads 2 cycles, word store 2, byte store 3, misaligned 1.
REQ-023 rsp_valid=1 in RESP only, for exactly one cycle; there is no back-pressure on responses.
REQ-024 Outside RESP, rsp_rdata=0 and rsp_err=0.
REQ-025 At most one request is outstanding; a new request can be accepted on the cycle after RESP at the earliest.
REQ-026 RAM reads are synchronous: address registered, data available on the next cycle.
REQ-027 Read-after-write to the same word in back-to-back requests SHALL return the newly written data.

Reset
REQ-028 While reset=1, the FSM is held in IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, and the captured request registers are cleared.
REQ-029 Reset asserted mid-operation abandons the request: no response is produced, and a byte store still in RD_WAIT performs no write.
REQ-030 RAM contents are not cleared by reset.

Structure
REQ-031 The state encoding, RAM depth/address-width constants and the access-type constants (byte/word, load/store) are defined in a shared processor package.
REQ-032 The RAM array is a separate sub-module, dmem_ram: single port, synchronous read, synchronous write, 1024x32.
REQ-033 All control logic resides in mem_responder.

Verification
REQ-034 Word store addr 0x10, data 0xDEADBEEF, then word load addr 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, each rsp_valid 2 cycles after acceptance.
REQ-035 Byte store 0xAA at addr 0x12 onto word 0xDEADBEEF, then word load 0x10 -> 0xDEAABEEF; byte store rsp_valid 3 cycles after acceptance.
REQ-036 Byte load addr 0x13 of word 0xDEAABEEF -> rsp_rdata=0x000000DE.
REQ-037 Word load addr 0x11 -> rsp_valid 1 cycle after acceptance, rsp_err=1, rsp_rdata=0; a following load of 0x10 is unaffected.
REQ-038 Word store 0x12345678 at addr 0x1004, then load addr 0x0004 -> 0x12345678 (4 KiB wrap).
REQ-039 Byte store accepted, then reset asserted during RD_WAIT -> no rsp_valid, target word unchanged, req_ready=1 after reset is released.
